spi_wb_regs: RTL

Wishbone-slave register file and control sequencer for the SPI master. Sits directly upstream of `spi_shift_reg`:
- drives its parallel-load data, byte lanes, character length, bit order, edge selects and `go`;
- reads back received data;
- exports the clock divider and the slave-select pads;
- raises an interrupt when a transfer completes.

---
 rtl/spi_wb_regs_pkg.sv | 28 ++
 rtl/spi_wb_regs_if.sv | 30 +++
 rtl/spi_wb_regs.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/spi_wb_regs_pkg.sv
// spi_wb_regs_pkg
// Shared constants for the SPI master register block:
//   - default shift-register, length-field, divider and slave-select widths
//   - register word offsets (byte address bits [4:2])
//   - CTRL register bit positions
package spi_wb_regs_pkg;

  localparam int SPI_MAX_CHAR      = 32;
  localparam int SPI_CHAR_LEN_BITS = 5;
  localparam int SPI_DIVIDER_LEN   = 16;
  localparam int SPI_SS_NB         = 8;

  // Register word index = byte address [4:2].
  typedef enum logic [2:0] {
    SPI_DATA   = 3'd0,  // 0x00
    SPI_CTRL   = 3'd4,  // 0x10
    SPI_DIVIDE = 3'd5,  // 0x14
    SPI_SS     = 3'd6   // 0x18
  } spi_reg_e;

  localparam int SPI_CTRL_GO     = 8;
  localparam int SPI_CTRL_RX_NEG = 9;
  localparam int SPI_CTRL_TX_NEG = 10;
  localparam int SPI_CTRL_LSB    = 11;
  localparam int SPI_CTRL_IE     = 12;
  localparam int SPI_CTRL_ASS    = 13;

endpackage

// File: rtl/spi_wb_regs_if.sv
// spi_wb_regs_if
// Wishbone classic slave bus as seen by the SPI register block.
//   wb_adr_i  5   byte address
//   wb_dat_i  32  write data
//   wb_dat_o  32  read data (registered in the slave)
//   wb_sel_i  4   byte lane selects
//   wb_we_i, wb_stb_i, wb_cyc_i  bus controls
//   wb_ack_o  acknowledge, wb_int_o  interrupt
// Modports: master (bus initiator) and slave (register block).
interface spi_wb_regs_if;
  logic [4:0]  wb_adr_i;
  logic [31:0] wb_dat_i;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_i;
  logic        wb_we_i;
  logic        wb_stb_i;
  logic        wb_cyc_i;
  logic        wb_ack_o;
  logic        wb_int_o;

  modport master (
    output wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    input  wb_dat_o, wb_ack_o, wb_int_o
  );

  modport slave (
    input  wb_adr_i, wb_dat_i, wb_sel_i, wb_we_i, wb_stb_i, wb_cyc_i,
    output wb_dat_o, wb_ack_o, wb_int_o
  );
endinterface

// File: rtl/spi_wb_regs.sv
// spi_wb_regs
// Wishbone register file and control sequencer for the SPI master. Holds
// CTRL / DIVIDER / SS, drives the shift register's parallel load and go
// request, reads back received data and flags transfer completion.
//
// Ports:
//   wb_clk_in, wb_rst     clock, asynchronous active-high reset
//   wb (slave modport)    Wishbone bus, ack and read data registered
//   p_in, byte_sel, latch parallel load towards the shift register
//   len, lsb, rx_negedge, tx_negedge, go   transfer configuration/request
//   p_out, tip, last      shift register status inputs
//   divider               clock generator divide value
//   ss_pad_o              active-low slave selects
//
// Configuration: define SPI_INT_EN to build the interrupt logic (CTRL.ie and
// the completion flag). Without it wb_int_o is tied low and CTRL[12] reads 0.
module spi_wb_regs #(
  parameter int SPI_MAX_CHAR      = spi_wb_regs_pkg::SPI_MAX_CHAR,
  parameter int SPI_CHAR_LEN_BITS = spi_wb_regs_pkg::SPI_CHAR_LEN_BITS,
  parameter int SPI_DIVIDER_LEN   = spi_wb_regs_pkg::SPI_DIVIDER_LEN,
  parameter int SPI_SS_NB         = spi_wb_regs_pkg::SPI_SS_NB
) (
  input  logic                         wb_clk_in,
  input  logic                         wb_rst,
  spi_wb_regs_if.slave                 wb,
  output logic [SPI_MAX_CHAR-1:0]      p_in,
  output logic [3:0]                   byte_sel,
  output logic [3:0]                   latch,
  output logic [SPI_CHAR_LEN_BITS-1:0] len,
  output logic                         lsb,
  output logic                         rx_negedge,
  output logic                         tx_negedge,
  output logic                         go,
  input  logic [SPI_MAX_CHAR-1:0]      p_out,
  input  logic                         tip,
  input  logic                         last,
  output logic [SPI_DIVIDER_LEN-1:0]   divider,
  output logic [SPI_SS_NB-1:0]         ss_pad_o
);
  import spi_wb_regs_pkg::*;

  logic [2:0]                   reg_idx;
  logic                         accept;
  logic                         busy;
  logic                         wr_en;
  logic                         done;
  logic                         tip_q;
  logic                         ack_q;
  logic [31:0]                  dat_q;
  logic [31:0]                  rd_data;
  logic                         go_q;
  logic [SPI_CHAR_LEN_BITS-1:0] char_len_q;
  logic                         rx_neg_q;
  logic                         tx_neg_q;
  logic                         lsb_q;
  logic                         ass_q;
  logic                         ie_q;
  logic                         int_pend;
  logic [SPI_DIVIDER_LEN-1:0]   divider_q;
  logic [SPI_SS_NB-1:0]         ss_q;

  assign reg_idx = wb.wb_adr_i[4:2];
  assign accept  = wb.wb_cyc_i & wb.wb_stb_i & ~ack_q;
  // go covers the gap between the request and the shift register raising tip.
  assign busy    = go_q | tip;
  assign wr_en   = accept & wb.wb_we_i & ~busy;
  assign done    = tip_q & ~tip;

  assign p_in       = wb.wb_dat_i[SPI_MAX_CHAR-1:0];
  assign byte_sel   = wb.wb_sel_i;
  assign latch      = {3'b000, wr_en & (reg_idx == SPI_DATA)};
  assign len        = char_len_q;
  assign lsb        = lsb_q;
  assign rx_negedge = rx_neg_q;
  assign tx_negedge = tx_neg_q;
  assign go         = go_q;
  assign divider    = divider_q;
  assign ss_pad_o   = ~(ass_q ? (ss_q & {SPI_SS_NB{tip}}) : ss_q);

  assign wb.wb_ack_o = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_int_o = int_pend;

  // Read mux; sampled into dat_q on the accept edge.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    rd_data = '0;
    case (reg_idx)
      SPI_DATA:   rd_data[SPI_MAX_CHAR-1:0] = p_out;
      SPI_CTRL: begin
        rd_data[SPI_CHAR_LEN_BITS-1:0] = char_len_q;
        rd_data[SPI_CTRL_GO]           = go_q;
        rd_data[SPI_CTRL_RX_NEG]       = rx_neg_q;
        rd_data[SPI_CTRL_TX_NEG]       = tx_neg_q;
        rd_data[SPI_CTRL_LSB]          = lsb_q;
        rd_data[SPI_CTRL_IE]           = ie_q;
        rd_data[SPI_CTRL_ASS]          = ass_q;
      end
      SPI_DIVIDE: rd_data[SPI_DIVIDER_LEN-1:0] = divider_q;
      SPI_SS:     rd_data[SPI_SS_NB-1:0] = ss_q;
      default:    rd_data = '0;
    endcase
  end

  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      tip_q      <= 1'b0;
      go_q       <= 1'b0;
      char_len_q <= '0;
      rx_neg_q   <= 1'b0;
      tx_neg_q   <= 1'b0;
      lsb_q      <= 1'b0;
      ass_q      <= 1'b0;
      divider_q  <= '1;
      ss_q       <= '0;
    end else begin
      // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
      ack_q <= accept;
      tip_q <= tip;
      if (accept) dat_q <= rd_data;
      if (wr_en) begin
        case (reg_idx)
          SPI_CTRL: begin
            char_len_q <= wb.wb_dat_i[SPI_CHAR_LEN_BITS-1:0];
            go_q       <= wb.wb_dat_i[SPI_CTRL_GO];
            rx_neg_q   <= wb.wb_dat_i[SPI_CTRL_RX_NEG];
            tx_neg_q   <= wb.wb_dat_i[SPI_CTRL_TX_NEG];
            lsb_q      <= wb.wb_dat_i[SPI_CTRL_LSB];
            ass_q      <= wb.wb_dat_i[SPI_CTRL_ASS];
          end
          SPI_DIVIDE: divider_q <= wb.wb_dat_i[SPI_DIVIDER_LEN-1:0];
          SPI_SS:     ss_q      <= wb.wb_dat_i[SPI_SS_NB-1:0];
          default: ;
        endcase
      end
      // A CTRL write cannot coincide with completion: busy blocks it.
      if (done) go_q <= 1'b0;
    end
  end

`ifdef SPI_INT_EN
  always_ff @(posedge wb_clk_in or posedge wb_rst) begin
    if (wb_rst) begin
      ie_q     <= 1'b0;
      int_pend <= 1'b0;
    end else begin
      if (wr_en && reg_idx == SPI_CTRL) ie_q <= wb.wb_dat_i[SPI_CTRL_IE];
      // Set has priority over the clear-on-access.
      if (done && ie_q)  int_pend <= 1'b1;
      else if (accept)   int_pend <= 1'b0;
    end
  end
`else
  assign ie_q     = 1'b0;
  assign int_pend = 1'b0;
`endif

  // last is status only; the low address bits are not decoded.
  logic unused_ok;
  assign unused_ok = &{1'b0, last, wb.wb_adr_i[1:0]};

endmodule
